store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 163 ++++++++++++++++
 tb/tb_store_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-store queue between the core and the data memory. Stores inside the
//   0x1001_0000..0x1001_FFFF window are queued in a DEPTH-entry circular FIFO
//   and drained oldest-first whenever the memory port is granted. Stores outside
//   the window are accepted and dropped, with a one-cycle st_oor pulse. A load
//   probe reports word-address conflicts with pending stores.
//
//   Optional feature (macro SB_FWD_EN): when the youngest pending store to the
//   probed word is a full-word store, its data is forwarded instead of stalling.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   st_valid/st_ready                 store request handshake
//   st_addr, st_data, st_funct3       store byte address, data, width code
//   mem_grant                         memory port available this cycle
//   mem_we, mem_addr, mem_din,
//   mem_funct3                        drain write of the oldest entry
//   ld_valid, ld_addr                 load probe
//   ld_stall                          probe conflicts with a pending store
//   ld_fwd_valid, ld_fwd_data         forwarded word (zero without SB_FWD_EN)
//   st_oor                            dropped out-of-range store pulse
//   empty                             no pending entries
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    input  logic        mem_grant,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [2:0]  mem_funct3,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        ld_fwd_valid,
    output logic [31:0] ld_fwd_data,
    output logic        st_oor,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          st_oor_q, st_oor_d;

    // Entry payload carries no reset: only the pointers/count define validity.
    logic [31:0] addr_q [DEPTH];
    logic [31:0] addr_d [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];
    logic [2:0]  f3_q   [DEPTH];
    logic [2:0]  f3_d   [DEPTH];

    logic push_acc, in_range, push, pop;

    assign empty    = (count_q == '0);
    assign st_ready = (count_q < CW'(DEPTH));
    assign st_oor   = st_oor_q;

    assign push_acc = st_valid && st_ready;
    assign in_range = (st_addr[31:16] == 16'h1001);
    assign push     = push_acc && in_range;
    assign pop      = mem_grant && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        st_oor_d = push_acc && !in_range;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        f3_d   = f3_q;
        if (push) begin
            addr_d[wr_ptr_q] = st_addr;
            data_d[wr_ptr_q] = st_data;
            f3_d[wr_ptr_q]   = st_funct3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_oor_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_oor_q <= st_oor_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        f3_q   <= f3_d;
    end

    // Drain port shows the oldest entry; zeroed when nothing is pending.
    assign mem_we     = pop;
    assign mem_addr   = empty ? 32'h0 : addr_q[rd_ptr_q];
    assign mem_din    = empty ? 32'h0 : data_q[rd_ptr_q];
    assign mem_funct3 = empty ? 3'b000 : f3_q[rd_ptr_q];

    // Walk entries oldest to youngest so the last hit is the youngest match.
    // The entry being popped this cycle is still counted as pending.
    logic [AW-1:0] probe_idx;
    logic          hit;
    logic          yng_word;
    logic [31:0]   yng_data;

    always_comb begin
        probe_idx = '0;
        hit       = 1'b0;
        yng_word  = 1'b0;
        yng_data  = 32'h0;
        for (int k = 0; k < DEPTH; k++) begin
            probe_idx = rd_ptr_q + AW'(k);
            if ((CW'(k) < count_q) && (addr_q[probe_idx][31:2] == ld_addr[31:2])) begin
                hit      = 1'b1;
                yng_word = (f3_q[probe_idx] == 3'b010);
                yng_data = data_q[probe_idx];
            end
        end
    end

    logic unused_ok;

`ifdef SB_FWD_EN
    assign ld_fwd_valid = ld_valid && hit && yng_word;
    assign ld_fwd_data  = ld_fwd_valid ? yng_data : 32'h0;
    assign ld_stall     = ld_valid && hit && !yng_word;
    assign unused_ok    = ^ld_addr[1:0];
`else
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'h0;
    assign ld_stall     = ld_valid && hit;
    assign unused_ok    = ^{yng_word, yng_data, ld_addr[1:0]};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Scoreboard bench for store_buffer (DEPTH=4). Accepted in-range stores are
//   queued as expected drain writes; a monitor pops and compares on every
//   mem_we. Inputs change on the falling edge, outputs are read shortly after.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        mem_grant;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [2:0]  mem_funct3;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        ld_fwd_valid;
    logic [31:0] ld_fwd_data;
    logic        st_oor;
    logic        empty;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    exp_t sb_q[$];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .mem_grant(mem_grant), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_funct3(mem_funct3),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
        .st_oor(st_oor), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drain monitor: every memory write must match the oldest expected store.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mem_we === 1'b1) begin
            vec_cnt++;
            if (sb_q.size() == 0) begin
                err_cnt++;
                $display("FAIL drain_unexpected: write addr=%h din=%h, none expected", mem_addr, mem_din);
            end else begin
                e = sb_q.pop_front();
                if ({mem_addr, mem_din, mem_funct3} !== e) begin
                    err_cnt++;
                    $display("FAIL drain_data: got %h/%h/%b want %h/%h/%b",
                             mem_addr, mem_din, mem_funct3, e.a, e.d, e.f);
                end
            end
        end
    end

    task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f;
    endtask

    task automatic drain_all(input string tag);
        int n;
        n = 0;
        mem_grant = 1'b1;
        #1;
        while (empty !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        mem_grant = 1'b0;
        vec_cnt++;
        if (empty !== 1'b1) begin err_cnt++; $display("FAIL %s_drain_timeout: empty=%b want 1", tag, empty); end
        vec_cnt++;
        if (sb_q.size() != 0) begin err_cnt++; $display("FAIL %s_sb_left: %0d writes missing, want 0", tag, sb_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_grant = 1'b1; ld_valid = 1'b1; ld_addr = 32'h1001_0000;
        set_store(1'b1, 32'h1001_0000, 32'h1111_1111, 3'b010);
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++; if (empty !== 1'b1)        begin err_cnt++; $display("FAIL rst_empty: got %b want 1", empty); end
        vec_cnt++; if (st_ready !== 1'b1)     begin err_cnt++; $display("FAIL rst_ready: got %b want 1", st_ready); end
        vec_cnt++; if (mem_we !== 1'b0)       begin err_cnt++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        vec_cnt++; if (ld_stall !== 1'b0)     begin err_cnt++; $display("FAIL rst_ld_stall: got %b want 0", ld_stall); end
        vec_cnt++; if (ld_fwd_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_fwd: got %b want 0", ld_fwd_valid); end
        vec_cnt++; if (st_oor !== 1'b0)       begin err_cnt++; $display("FAIL rst_oor: got %b want 0", st_oor); end
        vec_cnt++; if (mem_addr !== 32'h0)    begin err_cnt++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        @(negedge clk);
        rst_n = 1'b1; mem_grant = 1'b0; ld_valid = 1'b0;
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
    endtask

    task automatic test_single();
        mem_grant = 1'b0;
        set_store(1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 3'b010);
        #1;
        vec_cnt++; if (st_ready !== 1'b1) begin err_cnt++; $display("FAIL single_ready: got %b want 1", st_ready); end
        vec_cnt++; if (mem_we !== 1'b0)   begin err_cnt++; $display("FAIL single_no_bypass: got %b want 0", mem_we); end
        sb_q.push_back({32'h1001_0000, 32'hDEAD_BEEF, 3'b010});
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        vec_cnt++; if (empty !== 1'b0)  begin err_cnt++; $display("FAIL single_empty: got %b want 0", empty); end
        vec_cnt++; if (mem_we !== 1'b0) begin err_cnt++; $display("FAIL single_we_nogrant: got %b want 0", mem_we); end
        mem_grant = 1'b1;
        #1;
        vec_cnt++; if (mem_we !== 1'b1)           begin err_cnt++; $display("FAIL single_we: got %b want 1", mem_we); end
        vec_cnt++; if (mem_din !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL single_din: got %h want deadbeef", mem_din); end
        @(negedge clk);
        mem_grant = 1'b0;
        #1;
        vec_cnt++; if (empty !== 1'b1)     begin err_cnt++; $display("FAIL single_empty_after: got %b want 1", empty); end
        vec_cnt++; if (mem_din !== 32'h0)  begin err_cnt++; $display("FAIL single_din_zero: got %h want 0", mem_din); end
        vec_cnt++; if (sb_q.size() != 0)   begin err_cnt++; $display("FAIL single_sb: %0d left want 0", sb_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_full();
        mem_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 32'h1001_0020 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010);
            #1;
            vec_cnt++; if (st_ready !== 1'b1) begin err_cnt++; $display("FAIL full_ready_%0d: got %b want 1", i, st_ready); end
            sb_q.push_back({st_addr, st_data, st_funct3});
            @(negedge clk);
        end
        set_store(1'b1, 32'h1001_0030, 32'hA000_0004, 3'b010);
        #1;
        vec_cnt++; if (st_ready !== 1'b0) begin err_cnt++; $display("FAIL full_blocked: got %b want 0", st_ready); end
        @(negedge clk);
        mem_grant = 1'b1;
        #1;
        vec_cnt++; if (mem_we !== 1'b1)   begin err_cnt++; $display("FAIL full_pop_we: got %b want 1", mem_we); end
        vec_cnt++; if (st_ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready_same_cycle: got %b want 0", st_ready); end
        @(negedge clk);
        mem_grant = 1'b0;
        #1;
        vec_cnt++; if (st_ready !== 1'b1) begin err_cnt++; $display("FAIL full_slot_freed: got %b want 1", st_ready); end
        sb_q.push_back({32'h1001_0030, 32'hA000_0004, 3'b010});
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        vec_cnt++; if (st_ready !== 1'b0) begin err_cnt++; $display("FAIL full_again: got %b want 0", st_ready); end
        drain_all("full");
    endtask

    task automatic test_oor();
        logic [31:0] addrs [3];
        logic        oor_e [3];
        addrs[0] = 32'h2000_0000; oor_e[0] = 1'b1;
        addrs[1] = 32'h1002_0000; oor_e[1] = 1'b1;
        addrs[2] = 32'h1000_FFFC; oor_e[2] = 1'b1;
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, addrs[i], 32'h5555_0000 + 32'(i), 3'b010);
            @(negedge clk);
            st_valid = 1'b0;
            #1;
            vec_cnt++; if (st_oor !== oor_e[i]) begin err_cnt++; $display("FAIL oor_pulse_%0d: got %b want %b", i, st_oor, oor_e[i]); end
            vec_cnt++; if (empty !== 1'b1)      begin err_cnt++; $display("FAIL oor_empty_%0d: got %b want 1", i, empty); end
            @(negedge clk);
            #1;
            vec_cnt++; if (st_oor !== 1'b0)     begin err_cnt++; $display("FAIL oor_one_cycle_%0d: got %b want 0", i, st_oor); end
        end
        // Top byte of the window is in range.
        set_store(1'b1, 32'h1001_FFFF, 32'h0000_00EE, 3'b000);
        sb_q.push_back({32'h1001_FFFF, 32'h0000_00EE, 3'b000});
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        vec_cnt++; if (st_oor !== 1'b0) begin err_cnt++; $display("FAIL oor_top_edge: got %b want 0", st_oor); end
        vec_cnt++; if (empty !== 1'b0)  begin err_cnt++; $display("FAIL oor_top_queued: got %b want 0", empty); end
        drain_all("oor");
    endtask

    task automatic test_ld_stall();
        logic [31:0] la [4];
        logic        se [4];
        la[0] = 32'h1001_0004; se[0] = 1'b1;
        la[1] = 32'h1001_0007; se[1] = 1'b1;
        la[2] = 32'h1001_0008; se[2] = 1'b0;
        la[3] = 32'h1000_0004; se[3] = 1'b0;
        mem_grant = 1'b0;
        set_store(1'b1, 32'h1001_0005, 32'h0000_00AB, 3'b000);
        sb_q.push_back({32'h1001_0005, 32'h0000_00AB, 3'b000});
        @(negedge clk);
        st_valid = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_addr = la[i];
            #1;
            vec_cnt++; if (ld_stall !== se[i])    begin err_cnt++; $display("FAIL ld_stall_%0d: addr %h got %b want %b", i, la[i], ld_stall, se[i]); end
            vec_cnt++; if (ld_fwd_valid !== 1'b0) begin err_cnt++; $display("FAIL ld_nofwd_byte_%0d: got %b want 0", i, ld_fwd_valid); end
            @(negedge clk);
        end
        ld_valid = 1'b0; ld_addr = 32'h1001_0004;
        #1;
        vec_cnt++; if (ld_stall !== 1'b0) begin err_cnt++; $display("FAIL ld_stall_novalid: got %b want 0", ld_stall); end
        @(negedge clk);
        ld_valid = 1'b1; mem_grant = 1'b1;
        #1;
        vec_cnt++; if (ld_stall !== 1'b1) begin err_cnt++; $display("FAIL ld_stall_popping: got %b want 1", ld_stall); end
        @(negedge clk);
        mem_grant = 1'b0;
        #1;
        vec_cnt++; if (ld_stall !== 1'b0) begin err_cnt++; $display("FAIL ld_stall_after_drain: got %b want 0", ld_stall); end
        ld_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fwd();
        mem_grant = 1'b0;
        set_store(1'b1, 32'h1001_0010, 32'h1234_5678, 3'b010);
        sb_q.push_back({32'h1001_0010, 32'h1234_5678, 3'b010});
        @(negedge clk);
        set_store(1'b1, 32'h1001_0010, 32'hCAFE_F00D, 3'b010);
        sb_q.push_back({32'h1001_0010, 32'hCAFE_F00D, 3'b010});
        @(negedge clk);
        // Younger halfword store to the same word is queued on this edge.
        set_store(1'b1, 32'h1001_0012, 32'h0000_5555, 3'b001);
        sb_q.push_back({32'h1001_0012, 32'h0000_5555, 3'b001});
        ld_valid = 1'b1; ld_addr = 32'h1001_0010;
        #1;
`ifdef SB_FWD_EN
        vec_cnt++; if (ld_fwd_valid !== 1'b1)        begin err_cnt++; $display("FAIL fwd_valid: got %b want 1", ld_fwd_valid); end
        vec_cnt++; if (ld_fwd_data !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL fwd_data: got %h want cafef00d", ld_fwd_data); end
        vec_cnt++; if (ld_stall !== 1'b0)            begin err_cnt++; $display("FAIL fwd_stall: got %b want 0", ld_stall); end
`else
        vec_cnt++; if (ld_fwd_valid !== 1'b0)  begin err_cnt++; $display("FAIL nofwd_valid: got %b want 0", ld_fwd_valid); end
        vec_cnt++; if (ld_fwd_data !== 32'h0)  begin err_cnt++; $display("FAIL nofwd_data: got %h want 0", ld_fwd_data); end
        vec_cnt++; if (ld_stall !== 1'b1)      begin err_cnt++; $display("FAIL nofwd_stall: got %b want 1", ld_stall); end
`endif
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        vec_cnt++; if (ld_fwd_valid !== 1'b0) begin err_cnt++; $display("FAIL fwd_young_half: got %b want 0", ld_fwd_valid); end
        vec_cnt++; if (ld_stall !== 1'b1)     begin err_cnt++; $display("FAIL fwd_young_stall: got %b want 1", ld_stall); end
        ld_valid = 1'b0;
        @(negedge clk);
        drain_all("fwd");
    endtask

    task automatic test_back_to_back();
        logic [2:0] fv [6];
        fv[0] = 3'b010; fv[1] = 3'b111; fv[2] = 3'b000;
        fv[3] = 3'b011; fv[4] = 3'b001; fv[5] = 3'b110;
        mem_grant = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_store(1'b1, 32'h1001_FFFC - 32'(8 * i), 32'hB0B0_0000 ^ 32'(i * 32'h1357), fv[i]);
            #1;
            vec_cnt++; if (st_ready !== 1'b1)          begin err_cnt++; $display("FAIL b2b_ready_%0d: got %b want 1", i, st_ready); end
            vec_cnt++; if (mem_we !== (i > 0))         begin err_cnt++; $display("FAIL b2b_we_%0d: got %b want %b", i, mem_we, (i > 0)); end
            sb_q.push_back({st_addr, st_data, st_funct3});
            @(negedge clk);
        end
        st_valid = 1'b0;
        #1;
        vec_cnt++; if (mem_we !== 1'b1) begin err_cnt++; $display("FAIL b2b_last_we: got %b want 1", mem_we); end
        @(negedge clk);
        mem_grant = 1'b0;
        #1;
        vec_cnt++; if (empty !== 1'b1)    begin err_cnt++; $display("FAIL b2b_empty: got %b want 1", empty); end
        vec_cnt++; if (sb_q.size() != 0)  begin err_cnt++; $display("FAIL b2b_sb: %0d left want 0", sb_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_reset_pending();
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, 32'h1001_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 3'b010);
            @(negedge clk);
        end
        st_valid = 1'b0;
        #1;
        vec_cnt++; if (empty !== 1'b0) begin err_cnt++; $display("FAIL rstp_pending: got %b want 0", empty); end
        rst_n = 1'b0; mem_grant = 1'b1;
        #1;
        vec_cnt++; if (empty !== 1'b1)    begin err_cnt++; $display("FAIL rstp_empty: got %b want 1", empty); end
        vec_cnt++; if (mem_we !== 1'b0)   begin err_cnt++; $display("FAIL rstp_we: got %b want 0", mem_we); end
        vec_cnt++; if (st_ready !== 1'b1) begin err_cnt++; $display("FAIL rstp_ready: got %b want 1", st_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++; if (mem_we !== 1'b0) begin err_cnt++; $display("FAIL rstp_stale_we_%0d: got %b want 0", i, mem_we); end
            vec_cnt++; if (empty !== 1'b1)  begin err_cnt++; $display("FAIL rstp_stale_empty_%0d: got %b want 1", i, empty); end
            @(negedge clk);
        end
        mem_grant = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mem_grant = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0;
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_oor();
        test_ld_stall();
        test_fwd();
        test_back_to_back();
        test_reset_pending();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
